// File: rtl/quartsine_phase_gen.sv
// rtl/quartsine_phase_gen.sv - phase accumulator driving a quarter-wave sine table
// Mirrors the table address per quadrant and applies the sign around midscale.
module quartsine_phase_gen #(
    parameter int PHASE_W     = 24,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 11,
    parameter int ROM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] phase_step,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-2:0]  rom_data,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int CNT_W = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;
    logic               overrun_q, overrun_d;

    logic [1:0]         quad;
    logic [ADDR_W-1:0]  idx;
    logic [DATA_W-1:0]  rom_ext;
    logic               tick_en;

    always_comb begin
        quad    = acc_q[PHASE_W-1 -: 2];
        idx     = acc_q[PHASE_W-3 -: ADDR_W];
        rom_ext = {1'b0, rom_data};
        tick_en = sample_tick & en;

        state_d        = state_q;
        acc_d          = acc_q;
        rom_addr_d     = rom_addr_q;
        neg_d          = neg_q;
        cnt_d          = cnt_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        // A tick that lands while a read is in flight is lost, so remember it.
        overrun_d      = overrun_q | (tick_en & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (tick_en) begin
                    // Odd quadrants run the table backwards; the read uses the pre-increment phase.
                    rom_addr_d = quad[0] ? ~idx : idx;
                    neg_d      = quad[1];
                    acc_d      = acc_q + phase_step;
                    cnt_d      = CNT_W'(ROM_LATENCY);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                sample_d       = neg_q ? (MID - rom_ext) : (MID + rom_ext);
                sample_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            rom_addr_q     <= '0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            sample_q       <= MID;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            rom_addr_q     <= rom_addr_d;
            neg_q          <= neg_d;
            cnt_q          <= cnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_quartsine_phase_gen.sv
// tb/tb_quartsine_phase_gen.sv - self-checking bench for quartsine_phase_gen
// Bench ROM returns 4*addr one clock after the address.
module tb_quartsine_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sample_tick;
    logic [23:0] phase_step;
    logic [7:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [10:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int unsigned m_acc;
    logic [31:0] m_sample;
    logic [31:0] m_over;

    quartsine_phase_gen #(
        .PHASE_W    (24),
        .ADDR_W     (8),
        .DATA_W     (11),
        .ROM_LATENCY(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample_tick (sample_tick),
        .phase_step  (phase_step),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= {rom_addr, 2'b00};

    function automatic int unsigned ref_addr(input int unsigned ph);
        int unsigned quad;
        int unsigned idx;
        quad = (ph >> 22) & 3;
        idx  = (ph >> 14) & 255;
        return (quad % 2 == 1) ? 255 - idx : idx;
    endfunction

    function automatic int unsigned ref_sample(input int unsigned ph);
        int unsigned mag;
        mag = 4 * ref_addr(ph);
        return (((ph >> 22) & 3) >= 2) ? 1024 - mag : 1024 + mag;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_tick(input logic [23:0] step);
        int unsigned exp_addr;
        int unsigned exp_s;
        int lat;
        bit seen;
        @(negedge clk);
        check("valid_idle", {31'd0, sample_valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("overrun_hold", {31'd0, overrun}, m_over);
        en          = 1'b1;
        sample_tick = 1'b1;
        phase_step  = step;
        exp_addr    = ref_addr(m_acc);
        exp_s       = ref_sample(m_acc);
        m_acc       = (m_acc + step) & 32'h00FF_FFFF;
        @(negedge clk);
        sample_tick = 1'b0;
        check("rom_addr", {24'd0, rom_addr}, exp_addr);
        check("busy_wait", {31'd0, busy}, 32'd1);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (sample_valid) seen = 1'b1;
        end
        check("valid_latency", seen ? lat : 0, 32'd3);
        check("sample", {21'd0, sample}, exp_s);
        m_sample = exp_s;
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        sample_tick = 1'b0;
        phase_step  = '0;
        m_acc       = 0;
        m_sample    = 1024;
        m_over      = 0;
        repeat (3) @(negedge clk);
        check("rst_sample", {21'd0, sample}, 32'd1024);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // Full sweep of all four quadrants with step 0x4000, ending back at phase 0.
        for (int i = 0; i < 1024; i++) send_tick(24'h004000);
        check("sweep_wrap", m_acc, 32'd0);

        // Ticks with en low are ignored entirely.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample_tick = 1'b1;
            phase_step  = 24'h123457;
            @(negedge clk);
            sample_tick = 1'b0;
            check("en0_valid", {31'd0, sample_valid}, 32'd0);
            check("en0_busy", {31'd0, busy}, 32'd0);
            check("en0_sample", {21'd0, sample}, m_sample);
            check("en0_overrun", {31'd0, overrun}, 32'd0);
        end
        send_tick(24'h030000);
        send_tick(24'h001000);

        // Back-to-back tick: second one dropped, overrun becomes sticky.
        begin
            int unsigned exp_s;
            int vcount;
            @(negedge clk);
            sample_tick = 1'b1;
            phase_step  = 24'h050000;
            exp_s       = ref_sample(m_acc);
            m_acc       = (m_acc + 32'h050000) & 32'h00FF_FFFF;
            @(negedge clk);
            phase_step  = 24'h7FFFFF;
            @(negedge clk);
            sample_tick = 1'b0;
            check("overrun_set", {31'd0, overrun}, 32'd1);
            vcount = 0;
            for (int k = 0; k < 8; k++) begin
                if (sample_valid) vcount++;
                @(negedge clk);
            end
            check("overrun_one_valid", vcount, 32'd1);
            check("overrun_sample", {21'd0, sample}, exp_s);
            m_sample = exp_s;
            m_over   = 1;
        end
        send_tick(24'h000000);
        send_tick(24'h020000);

        // Asynchronous reset in the middle of a read.
        @(negedge clk);
        sample_tick = 1'b1;
        phase_step  = 24'h123456;
        @(negedge clk);
        sample_tick = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_sample", {21'd0, sample}, 32'd1024);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        check("arst_addr", {24'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_valid", {31'd0, sample_valid}, 32'd0);
        m_acc    = 0;
        m_sample = 1024;
        m_over   = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_valid", {31'd0, sample_valid}, 32'd0);
        end

        // Wrap from 0x800000 by 0xC00000 lands at 0x400000 (quad1 mirror).
        send_tick(24'h800000);
        send_tick(24'hC00000);
        check("wrap_acc", m_acc, 32'h400000);
        send_tick(24'h000000);
        check("wrap_sample", {21'd0, sample}, 32'd2044);
        send_tick(24'h000000);

        // Random steps and spacing, with occasional disabled ticks.
        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                en          = 1'b0;
                sample_tick = 1'b1;
                phase_step  = 24'($urandom);
                @(negedge clk);
                sample_tick = 1'b0;
                check("rnd_en0_valid", {31'd0, sample_valid}, 32'd0);
            end
            send_tick(24'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
